// File: rtl/pll_sup_pkg.sv
// Shared definitions for the PLL lock supervisor.
//   state_t   : supervisor FSM state, encoding is visible on the LED debug port
//   RETRY_W   : width of the per-sequence retry counter
//   LOSS_W    : width of the lock-loss counter
//   min_cnt_w : smallest counter width able to hold the largest timing parameter
package pll_sup_pkg;

  typedef enum logic [2:0] {
    ST_PLLRST = 3'd0,
    ST_WAIT   = 3'd1,
    ST_STABLE = 3'd2,
    ST_RUN    = 3'd3,
    ST_FAIL   = 3'd4
  } state_t;

  localparam int RETRY_W = 2;
  localparam int LOSS_W  = 4;

  function automatic int min_cnt_w(input int rst_hold, input int lock_timeout,
                                   input int lock_stable);
    int m;
    m = rst_hold;
    if (lock_timeout > m) m = lock_timeout;
    if (lock_stable > m) m = lock_stable;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/sync_2ff_edge.sv
// Two-flop synchronizer with optional rising-edge pulse.
//   iSysClk  : destination clock
//   iSysRstn : asynchronous active-low reset, clears both stages
//   iD       : asynchronous input
//   oQ       : synchronized level (second flop)
//   oRise    : one-cycle pulse on a synchronized 0->1 transition (pEdge=1),
//              constant 0 when pEdge=0
module sync_2ff_edge #(
  parameter int pEdge = 0
) (
  input  logic iSysClk,
  input  logic iSysRstn,
  input  logic iD,
  output logic oQ,
  output logic oRise
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge iSysClk or negedge iSysRstn) begin
    if (!iSysRstn) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
    end else begin
      r_meta <= iD;
      r_sync <= r_meta;
    end
  end

  assign oQ = r_sync;

  generate
    if (pEdge != 0) begin : g_edge
      logic r_prev;

      always_ff @(posedge iSysClk or negedge iSysRstn) begin
        if (!iSysRstn) begin
          r_prev <= 1'b0;
        end else begin
          r_prev <= r_sync;
        end
      end

      // Both operands are flop outputs, so the pulse is glitch-free and
      // lasts exactly one cycle.
      assign oRise = r_sync & ~r_prev;
    end else begin : g_level
      assign oRise = 1'b0;
    end
  endgenerate

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset sequencer and lock supervisor; source of the qualified user reset.
// Holds the PLL in reset, waits for lock, qualifies lock stability, then
// releases the downstream reset. Lock timeouts retry a bounded number of
// times before parking in a sticky failure state; a manual push switch
// restarts the sequence from any state.
//   iSysClk    : free-running oscillator clock
//   iSysRstn   : asynchronous active-low reset
//   iPllLoked  : PLL lock indication, asynchronous
//   iManualRst : push switch, active-high, asynchronous
//   oPllRst    : PLL reset, active-high
//   oUserRstn  : qualified downstream reset, active-low
//   oLockFail  : retries exhausted, sticky until manual restart or iSysRstn
//   oState     : current FSM state (LED debug)
//   oRetryCnt  : retries used in the current sequence, saturating
//   oLossCnt   : lock losses seen while running, saturating
module pll_lock_supervisor
  import pll_sup_pkg::*;
#(
  parameter int pRstHold     = 100,
  parameter int pLockTimeout = 65536,
  parameter int pLockStable  = 1024,
  parameter int pMaxRetry    = 3,
  parameter int pCntW        = 17
) (
  input  logic               iSysClk,
  input  logic               iSysRstn,
  input  logic               iPllLoked,
  input  logic               iManualRst,
  output logic               oPllRst,
  output logic               oUserRstn,
  output logic               oLockFail,
  output logic [2:0]         oState,
  output logic [RETRY_W-1:0] oRetryCnt,
  output logic [LOSS_W-1:0]  oLossCnt
);

  // Elaboration-time parameter sanity.
  if (pCntW < min_cnt_w(pRstHold, pLockTimeout, pLockStable)) begin : g_chk_cntw
    $error("pCntW too narrow for the timing parameters");
  end
  if (pRstHold < 1 || pLockTimeout < 1 || pLockStable < 1) begin : g_chk_timing
    $error("timing parameters must be at least 1");
  end
  if (pMaxRetry < 0 || pMaxRetry > (2 ** RETRY_W) - 1) begin : g_chk_retry
    $error("pMaxRetry does not fit the retry counter");
  end

  localparam logic [pCntW-1:0]   RST_HOLD_M1 = pCntW'(pRstHold - 1);
  localparam logic [pCntW-1:0]   TIMEOUT_M1  = pCntW'(pLockTimeout - 1);
  localparam logic [pCntW-1:0]   STABLE_M1   = pCntW'(pLockStable - 1);
  localparam logic [pCntW-1:0]   CNT_ONE     = pCntW'(1);
  localparam logic [RETRY_W-1:0] RETRY_LIM   = RETRY_W'(pMaxRetry);

  function automatic logic [RETRY_W-1:0] sat_inc_retry(input logic [RETRY_W-1:0] v);
    return (v == {RETRY_W{1'b1}}) ? v : v + RETRY_W'(1);
  endfunction

  function automatic logic [LOSS_W-1:0] sat_inc_loss(input logic [LOSS_W-1:0] v);
    return (v == {LOSS_W{1'b1}}) ? v : v + LOSS_W'(1);
  endfunction

  logic w_lock;
  logic w_man_pulse;
  logic w_lock_rise_unused;
  logic w_man_level_unused;

  sync_2ff_edge #(.pEdge(0)) u_sync_lock (
    .iSysClk  (iSysClk),
    .iSysRstn (iSysRstn),
    .iD       (iPllLoked),
    .oQ       (w_lock),
    .oRise    (w_lock_rise_unused)
  );

  sync_2ff_edge #(.pEdge(1)) u_sync_man (
    .iSysClk  (iSysClk),
    .iSysRstn (iSysRstn),
    .iD       (iManualRst),
    .oQ       (w_man_level_unused),
    .oRise    (w_man_pulse)
  );

  state_t             r_state;
  logic [pCntW-1:0]   r_cnt;
  logic               r_pll_rst;
  logic               r_user_rstn;
  logic               r_lock_fail;
  logic [RETRY_W-1:0] r_retry;
  logic [LOSS_W-1:0]  r_loss;

  // Outputs are updated together with the state register so that each one
  // changes only on entry to or exit from a state.
  always_ff @(posedge iSysClk or negedge iSysRstn) begin
    if (!iSysRstn) begin
      r_state     <= ST_PLLRST;
      r_cnt       <= '0;
      r_pll_rst   <= 1'b1;
      r_user_rstn <= 1'b0;
      r_lock_fail <= 1'b0;
      r_retry     <= '0;
      r_loss      <= '0;
    end else if (w_man_pulse) begin
      // Manual restart overrides any other transition; loss history is kept.
      r_state     <= ST_PLLRST;
      r_cnt       <= '0;
      r_pll_rst   <= 1'b1;
      r_user_rstn <= 1'b0;
      r_lock_fail <= 1'b0;
      r_retry     <= '0;
    end else begin
      case (r_state)
        ST_PLLRST: begin
          if (r_cnt == RST_HOLD_M1) begin
            r_state   <= ST_WAIT;
            r_cnt     <= '0;
            r_pll_rst <= 1'b0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        ST_WAIT: begin
          // Lock is tested first so it wins over a coincident timeout.
          if (w_lock) begin
            r_state <= ST_STABLE;
            r_cnt   <= '0;
          end else if (r_cnt == TIMEOUT_M1) begin
            r_cnt     <= '0;
            r_pll_rst <= 1'b1;
            if (r_retry < RETRY_LIM) begin
              r_state <= ST_PLLRST;
              r_retry <= sat_inc_retry(r_retry);
            end else begin
              r_state     <= ST_FAIL;
              r_lock_fail <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        ST_STABLE: begin
          // A dropout here is a glitch: back to lock wait with a fresh
          // timeout, the retry budget is untouched.
          if (!w_lock) begin
            r_state <= ST_WAIT;
            r_cnt   <= '0;
          end else if (r_cnt == STABLE_M1) begin
            r_state     <= ST_RUN;
            r_cnt       <= '0;
            r_user_rstn <= 1'b1;
            r_retry     <= '0;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end

        ST_RUN: begin
          if (!w_lock) begin
            r_state     <= ST_PLLRST;
            r_cnt       <= '0;
            r_pll_rst   <= 1'b1;
            r_user_rstn <= 1'b0;
            r_loss      <= sat_inc_loss(r_loss);
          end
        end

        ST_FAIL: begin
          r_state <= ST_FAIL;
        end

        default: begin
          r_state     <= ST_PLLRST;
          r_cnt       <= '0;
          r_pll_rst   <= 1'b1;
          r_user_rstn <= 1'b0;
        end
      endcase
    end
  end

  assign oPllRst   = r_pll_rst;
  assign oUserRstn = r_user_rstn;
  assign oLockFail = r_lock_fail;
  assign oState    = r_state;
  assign oRetryCnt = r_retry;
  assign oLossCnt  = r_loss;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Scoreboard bench for pll_lock_supervisor. Stimulus pushes the expected
// state-transition records (state, outputs, and cycles spent in the state
// being left); the monitor pops one record on every observed oState change.
module tb_pll_lock_supervisor;
  import pll_sup_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       lock;
  logic       man;
  logic       pll_rst;
  logic       user_rstn;
  logic       lock_fail;
  logic [2:0] state;
  logic [1:0] retry;
  logic [3:0] loss;

  pll_lock_supervisor #(
    .pRstHold     (4),
    .pLockTimeout (20),
    .pLockStable  (8),
    .pMaxRetry    (2),
    .pCntW        (5)
  ) dut (
    .iSysClk    (clk),
    .iSysRstn   (rst_n),
    .iPllLoked  (lock),
    .iManualRst (man),
    .oPllRst    (pll_rst),
    .oUserRstn  (user_rstn),
    .oLockFail  (lock_fail),
    .oState     (state),
    .oRetryCnt  (retry),
    .oLossCnt   (loss)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [2:0] st;
    logic       pll;
    logic       urst;
    logic       lf;
    logic [1:0] rc;
    logic [3:0] lc;
    int         dwell;   // cycles in the previous state, -1 = not checked
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  int   exp_loss;

  task automatic chk(input string name, input int act, input int req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic push(input logic [2:0] st, input logic pll, input logic urst,
                      input logic lf, input logic [1:0] rc, input logic [3:0] lc,
                      input int dwell);
    exp_t e;
    e.st = st; e.pll = pll; e.urst = urst; e.lf = lf;
    e.rc = rc; e.lc = lc; e.dwell = dwell;
    exp_q.push_back(e);
  endtask

  task automatic wait_state(input logic [2:0] st, input int maxc, input string name);
    for (int i = 0; i < maxc; i++) begin
      @(negedge clk);
      if (state == st) break;
    end
    chk(name, int'(state), int'(st));
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"},  int'(state), 0);
    chk({tag, "_pllrst"}, int'(pll_rst), 1);
    chk({tag, "_urstn"},  int'(user_rstn), 0);
    chk({tag, "_lfail"},  int'(lock_fail), 0);
    chk({tag, "_retry"},  int'(retry), 0);
    chk({tag, "_loss"},   int'(loss), 0);
  endtask

  // Monitor: compares every state transition against the next record.
  initial begin : monitor
    logic [2:0] prev_st;
    int         dwell;
    int         idx;
    exp_t       e;
    prev_st = 3'd0;
    dwell   = 1;
    idx     = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_st = 3'd0;
        dwell   = 1;
      end else if (state != prev_st) begin
        if (exp_q.size() == 0) begin
          chk($sformatf("unexpected_transition_from_%0d", prev_st), int'(state), int'(prev_st));
        end else begin
          e = exp_q.pop_front();
          chk($sformatf("tr%0d_state", idx),  int'(state), int'(e.st));
          chk($sformatf("tr%0d_pllrst", idx), int'(pll_rst), int'(e.pll));
          chk($sformatf("tr%0d_urstn", idx),  int'(user_rstn), int'(e.urst));
          chk($sformatf("tr%0d_lfail", idx),  int'(lock_fail), int'(e.lf));
          chk($sformatf("tr%0d_retry", idx),  int'(retry), int'(e.rc));
          chk($sformatf("tr%0d_loss", idx),   int'(loss), int'(e.lc));
          if (e.dwell >= 0) chk($sformatf("tr%0d_dwell", idx), dwell, e.dwell);
        end
        idx++;
        prev_st = state;
        dwell   = 1;
      end else begin
        dwell++;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog timeout actual=running required=finished");
    $fatal(1, "bench timeout");
  end

  initial begin : stimulus
    rst_n = 1'b0;
    lock  = 1'b0;
    man   = 1'b0;

    repeat (3) @(negedge clk);
    #1;
    chk_reset_vals("reset");

    // Nominal bring-up: lock raised after cycle 10.
    push(ST_WAIT,   1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 4);
    push(ST_STABLE, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 9);
    push(ST_RUN,    1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 8);
    @(negedge clk);
    #2 rst_n = 1'b1;
    repeat (10) @(posedge clk);
    #1 lock = 1'b1;
    wait_state(ST_RUN, 60, "nominal_run");

    // Lock loss, then a one-cycle dropout during qualification.
    push(ST_PLLRST, 1'b1, 1'b0, 1'b0, 2'd0, 4'd1, 4);
    push(ST_WAIT,   1'b0, 1'b0, 1'b0, 2'd0, 4'd1, 4);
    push(ST_STABLE, 1'b0, 1'b0, 1'b0, 2'd0, 4'd1, 4);
    push(ST_WAIT,   1'b0, 1'b0, 1'b0, 2'd0, 4'd1, 5);
    push(ST_STABLE, 1'b0, 1'b0, 1'b0, 2'd0, 4'd1, 1);
    push(ST_RUN,    1'b0, 1'b1, 1'b0, 2'd0, 4'd1, 8);
    @(posedge clk);
    #1 lock = 1'b0;
    wait_state(ST_WAIT, 30, "glitch_wait");
    @(posedge clk);
    #1 lock = 1'b1;
    repeat (5) @(posedge clk);
    #1 lock = 1'b0;
    @(posedge clk);
    #1 lock = 1'b1;
    wait_state(ST_RUN, 60, "glitch_run");

    // Lock loss followed by no lock at all: two retries, then failure.
    push(ST_PLLRST, 1'b1, 1'b0, 1'b0, 2'd0, 4'd2, 4);
    push(ST_WAIT,   1'b0, 1'b0, 1'b0, 2'd0, 4'd2, 4);
    push(ST_PLLRST, 1'b1, 1'b0, 1'b0, 2'd1, 4'd2, 20);
    push(ST_WAIT,   1'b0, 1'b0, 1'b0, 2'd1, 4'd2, 4);
    push(ST_PLLRST, 1'b1, 1'b0, 1'b0, 2'd2, 4'd2, 20);
    push(ST_WAIT,   1'b0, 1'b0, 1'b0, 2'd2, 4'd2, 4);
    push(ST_FAIL,   1'b1, 1'b0, 1'b1, 2'd2, 4'd2, 20);
    @(posedge clk);
    #1 lock = 1'b0;
    wait_state(ST_FAIL, 200, "timeout_fail");
    repeat (30) @(negedge clk);
    chk("fail_hold_state",  int'(state), 4);
    chk("fail_hold_pllrst", int'(pll_rst), 1);
    chk("fail_hold_lfail",  int'(lock_fail), 1);

    // Manual recovery from failure.
    push(ST_PLLRST, 1'b1, 1'b0, 1'b0, 2'd0, 4'd2, -1);
    push(ST_WAIT,   1'b0, 1'b0, 1'b0, 2'd0, 4'd2, 4);
    push(ST_STABLE, 1'b0, 1'b0, 1'b0, 2'd0, 4'd2, 4);
    push(ST_RUN,    1'b0, 1'b1, 1'b0, 2'd0, 4'd2, 8);
    @(posedge clk);
    #1 man = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("manual_lfail_before", int'(lock_fail), 1);
    @(posedge clk);
    #1 chk("manual_lfail_after", int'(lock_fail), 0);
    chk("manual_state_after", int'(state), 0);
    repeat (2) @(posedge clk);
    #1 man = 1'b0;
    wait_state(ST_WAIT, 30, "manual_wait");
    @(posedge clk);
    #1 lock = 1'b1;
    wait_state(ST_RUN, 60, "manual_run");

    // Repeated lock losses: loss counter saturates.
    exp_loss = 2;
    for (int i = 0; i < 15; i++) begin
      exp_loss = (exp_loss == 15) ? 15 : exp_loss + 1;
      push(ST_PLLRST, 1'b1, 1'b0, 1'b0, 2'd0, 4'(exp_loss), 4);
      push(ST_WAIT,   1'b0, 1'b0, 1'b0, 2'd0, 4'(exp_loss), 4);
      push(ST_STABLE, 1'b0, 1'b0, 1'b0, 2'd0, 4'(exp_loss), 4);
      push(ST_RUN,    1'b0, 1'b1, 1'b0, 2'd0, 4'(exp_loss), 8);
      @(posedge clk);
      #1 lock = 1'b0;
      wait_state(ST_WAIT, 30, "loss_wait");
      @(posedge clk);
      #1 lock = 1'b1;
      wait_state(ST_RUN, 60, "loss_run");
    end
    chk("loss_saturated", int'(loss), 15);

    // Asynchronous reset while qualifying lock.
    push(ST_PLLRST, 1'b1, 1'b0, 1'b0, 2'd0, 4'd15, 4);
    push(ST_WAIT,   1'b0, 1'b0, 1'b0, 2'd0, 4'd15, 4);
    push(ST_STABLE, 1'b0, 1'b0, 1'b0, 2'd0, 4'd15, 4);
    @(posedge clk);
    #1 lock = 1'b0;
    wait_state(ST_WAIT, 30, "areset_wait");
    @(posedge clk);
    #1 lock = 1'b1;
    wait_state(ST_STABLE, 30, "areset_stable");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk_reset_vals("async_reset");

    // After release lock is already present: immediate qualification.
    push(ST_WAIT,   1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 4);
    push(ST_STABLE, 1'b0, 1'b0, 1'b0, 2'd0, 4'd0, 1);
    push(ST_RUN,    1'b0, 1'b1, 1'b0, 2'd0, 4'd0, 8);
    @(negedge clk);
    #2 rst_n = 1'b1;
    wait_state(ST_RUN, 40, "post_reset_run");

    repeat (5) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
